serial_addsub_n: RTL and testbench
==================================

Name: serial_addsub_n

Overview:
- Parametrised bit-serial successor to the team's 3-input/2-output full-adder cell: one full-adder slice plus a carry flip-flop, iterated LSB-first over WIDTH cycles.
- Adds or subtracts two WIDTH-bit operands.
- Start/done handshake with registered results.
- Used wherever area matters more than latency; the combinational cell remains the single-bit reference model.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in for add; ignored when sub=1; captured on the accepting edge.
- sub  input  1  0 = A+B+cin, 1 = A-B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out (add); registered not-borrow (sub).
- ovf  output  1  registered two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry flip-flop and counter cleared.
  - Applies immediately, including mid-RUN; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: load shift-A = a.
  - Load shift-B = sub ? ~b : b.
  - Set carry = sub ? 1 : cin; clear counter to 0; latch sub; go to RUN.
  - With start = 0: stay in IDLE.
- RUN, each edge:
  - s = A[0] ^ B[0] ^ carry.
  - carry <= majority(A[0], B[0], carry).
  - Shift A and B right by one.
  - Shift s into the MSB of the internal result register.
  - Increment the counter.
- RUN, edge where counter == WIDTH-1 (the last bit):
  - sum <= final result.
  - cout <= new carry.
  - ovf <= carry-into-MSB XOR carry-out of MSB.
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - start is ignored in DONE and in RUN; there is no queuing.
- Outputs and latency:
  - busy = (state == RUN).
  - done = (state == DONE).
  - Accept edge E0 → RUN edges E1..E_WIDTH → done high in the cycle after E_WIDTH.
  - Latency from accept to done = WIDTH+1 edges; throughput is one operation per WIDTH+2 cycles.
- sum, cout and ovf change only on the RUN→DONE edge or at reset; they hold their value through IDLE until the next completion.
- Inputs a, b, cin and sub may change freely after the accept edge without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH. cout reflects bit WIDTH of the unsigned (WIDTH+1)-bit result.
- start held high continuously: the block re-accepts on the first IDLE edge after DONE, one operation every WIDTH+2 cycles.
- Reset asserted in the same cycle as start: reset wins, nothing is accepted.

Test Plan:
- WIDTH=8, rst_n low then release; a=8'h35, b=8'h4A, cin=0, sub=0, start pulse → busy for 8 cycles; done 9 edges after accept; sum=8'h7F, cout=0, ovf=0.
- WIDTH=8 add with wrap: a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 → sum=8'h80, ovf=1.
- WIDTH=8 subtract: a=8'h10, b=8'h20, sub=1, cin=1 (must be ignored) → sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- WIDTH=4 exhaustive: all 16×16×2 (a, b) × cin combinations with sub=0; each result checked bit-for-bit against the combinational full-adder cell chained 4 times. Also check that sum/cout hold stable in IDLE between operations.
- WIDTH=8, start pulses in RUN and DONE, and operand/sub changes mid-RUN → no effect on the current result; no extra done pulse.
- WIDTH=8, rst_n dropped at RUN cycle 4 → outputs 0 and busy=0 immediately (asynchronous); after release, a fresh start with a=8'h01, b=8'h02 → sum=8'h03.

Source files
------------

// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop iterated
// LSB-first over WIDTH cycles, with a start/done handshake and registered results.
`timescale 1ns/1ps

module serial_addsub_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;

    serial_addsub_full_adder u_slice (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Subtraction is A + ~B + 1, so the operand inversion and the forced
    // carry-in happen once at accept time and the slice never needs to know.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                // On the MSB slice carry_q is the carry into the sign bit.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_d;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Scoreboard bench for serial_addsub_n: an 8-bit instance driven with directed
// vectors and a 4-bit instance swept against a chained full-adder reference.
`timescale 1ns/1ps

module tb_serial_addsub_n;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp8_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp4_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, sub4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    exp8_t sb8[$];
    exp4_t sb4[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic prev_done8 = 1'b0;
    logic prev_done4 = 1'b0;

    serial_addsub_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Single-bit full-adder cell chained four times; returns {ovf, cout, sum}.
    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic       c;
        logic       c3;
        logic [3:0] s;
        c  = ci;
        c3 = 1'b0;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c3 = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c3 ^ c, c, s};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done8) begin
            checkOutput("done8_single_cycle", 32'(prev_done8), 32'(0));
            checkOutput("done8_expected", 32'(sb8.size() != 0), 32'(1));
            if (sb8.size() != 0) begin
                exp8_t e;
                e = sb8.pop_front();
                checkOutput("sum8", 32'(sum8), 32'(e.sum));
                checkOutput("cout8", 32'(cout8), 32'(e.cout));
                checkOutput("ovf8", 32'(ovf8), 32'(e.ovf));
            end
        end
        prev_done8 = rst_n && done8;
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            checkOutput("done4_single_cycle", 32'(prev_done4), 32'(0));
            checkOutput("done4_expected", 32'(sb4.size() != 0), 32'(1));
            if (sb4.size() != 0) begin
                exp4_t e;
                e = sb4.pop_front();
                checkOutput("sum4", 32'(sum4), 32'(e.sum));
                checkOutput("cout4", 32'(cout4), 32'(e.cout));
                checkOutput("ovf4", 32'(ovf4), 32'(e.ovf));
            end
        end
        prev_done4 = rst_n && done4;
    end

    task automatic wait_idle8();
        int n;
        n = 0;
        while ((busy8 || done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy8 || done8) checkOutput("idle8_timeout", 32'(busy8 || done8), 32'(0));
    endtask

    // Issues one 8-bit operation and returns at the negedge where done is seen.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                                 input logic sb, input logic [7:0] es, input logic ec,
                                 input logic eo, input logic timing);
        int lat;
        int busy_n;
        wait_idle8();
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; sub8 = sb; start8 = 1'b1;
        sb8.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk);
        lat = 0;
        busy_n = 0;
        forever begin
            @(negedge clk);
            start8 = 1'b0;
            lat++;
            if (busy8) busy_n++;
            if (done8) break;
            if (lat > 40) begin
                checkOutput("done8_timeout", 32'(done8), 32'(1));
                break;
            end
        end
        if (timing) begin
            checkOutput("latency8_negedges", 32'(lat), 32'(9));
            checkOutput("busy8_cycles", 32'(busy_n), 32'(8));
        end
    endtask

    task automatic applyStimulus4(input logic [3:0] av, input logic [3:0] bv, input logic ci);
        logic [5:0] r;
        int         n;
        r = ref4(av, bv, ci);
        @(negedge clk);
        a4 = av; b4 = bv; cin4 = ci; sub4 = 1'b0; start4 = 1'b1;
        sb4.push_back('{sum: r[3:0], cout: r[4], ovf: r[5]});
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            start4 = 1'b0;
            a4 = ~av; b4 = ~bv; cin4 = ~ci;
            n++;
            if (done4) break;
            if (n > 20) begin
                checkOutput("done4_timeout", 32'(done4), 32'(1));
                break;
            end
        end
        @(negedge clk);
        checkOutput("sum4_hold_idle", 32'(sum4), 32'(r[3:0]));
        checkOutput("cout4_hold_idle", 32'(cout4), 32'(r[4]));
    endtask

    initial begin
        int   n;
        int   t_first;
        int   t_second;
        int   seen;
        int   busy_seen;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

        // Reset held while start is requested: nothing must be accepted.
        repeat (2) @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy8", 32'(busy8), 32'(0));
        checkOutput("reset_done8", 32'(done8), 32'(0));
        checkOutput("reset_sum8", 32'(sum8), 32'(0));
        checkOutput("reset_cout8", 32'(cout8), 32'(0));
        checkOutput("reset_ovf8", 32'(ovf8), 32'(0));

        $display("[TB] directed 8-bit vectors");
        applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] start pulses and operand changes while busy");
        wait_idle8();
        @(negedge clk);
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        sb8.push_back('{sum: 8'h7F, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        n = 0;
        seen = 0;
        while (n < 30 && seen == 0) begin
            @(negedge clk);
            n++;
            a8 = 8'(n * 37); b8 = 8'(n * 91); sub8 = n[0]; cin8 = ~n[0];
            start8 = n[1];
            if (done8) begin
                start8 = 1'b1;
                seen = 1;
            end
        end
        checkOutput("midrun_done_seen", 32'(seen), 32'(1));
        @(negedge clk);
        start8 = 1'b0;
        busy_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy8) busy_seen++;
        end
        checkOutput("no_extra_accept_busy8", 32'(busy_seen), 32'(0));

        $display("[TB] start held high across two operations");
        wait_idle8();
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'hF1; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
        sb8.push_back('{sum: 8'h1E, cout: 1'b0, ovf: 1'b0});
        sb8.push_back('{sum: 8'h1E, cout: 1'b0, ovf: 1'b0});
        n = 0; seen = 0; t_first = 0; t_second = 0;
        while (n < 40 && seen < 2) begin
            @(negedge clk);
            n++;
            if (done8) begin
                seen++;
                if (seen == 1) t_first = n;
                else t_second = n;
            end
        end
        start8 = 1'b0;
        checkOutput("b2b_done_count", 32'(seen), 32'(2));
        checkOutput("b2b_interval", 32'(t_second - t_first), 32'(10));

        $display("[TB] asynchronous reset in the middle of an operation");
        wait_idle8();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy8", 32'(busy8), 32'(0));
        checkOutput("async_rst_done8", 32'(done8), 32'(0));
        checkOutput("async_rst_sum8", 32'(sum8), 32'(0));
        checkOutput("async_rst_cout8", 32'(cout8), 32'(0));
        checkOutput("async_rst_ovf8", 32'(ovf8), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);

        $display("[TB] exhaustive 4-bit add sweep");
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    applyStimulus4(4'(ai), 4'(bi), ci[0]);
                end
            end
        end

        repeat (15) @(negedge clk);
        checkOutput("sb8_drained", 32'(sb8.size()), 32'(0));
        checkOutput("sb4_drained", 32'(sb4.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
